// File: rtl/ahb_lite_mem_slave.sv
// AHB-Lite memory slave: sized byte-lane writes, full-word reads, programmable
// wait states and a two-cycle ERROR response for out-of-range or malformed transfers.
module ahb_lite_mem_slave #(
   parameter int DATAWIDTH   = 32,
   parameter int ADDRWIDTH   = 32,
   parameter int MEM_DEPTH   = 256,
   parameter int WAIT_STATES = 0
) (
   input  logic                 HCLK,
   input  logic                 HRESETn,
   input  logic                 HSEL,
   input  logic [ADDRWIDTH-1:0] HADDR,
   input  logic [1:0]           HTRANS,
   input  logic                 HWRITE,
   input  logic [2:0]           HSIZE,
   input  logic [2:0]           HBURST,
   input  logic [3:0]           HPROT,
   input  logic                 HMASTLOCK,
   input  logic                 HREADY,
   input  logic [DATAWIDTH-1:0] HWDATA,
   output logic [DATAWIDTH-1:0] HRDATA,
   output logic                 HREADYOUT,
   output logic                 HRESP
);

   localparam int BYTES     = DATAWIDTH / 8;
   localparam int LANE_BITS = $clog2(BYTES);
   localparam int WORD_AW   = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
   localparam int REG_AW    = LANE_BITS + WORD_AW;
   localparam logic [ADDRWIDTH:0] MEM_BYTES = (ADDRWIDTH + 1)'(MEM_DEPTH * BYTES);
   localparam logic [2:0]         MAX_SIZE  = 3'(LANE_BITS);
   localparam logic [3:0]         WAIT_LOAD = 4'(WAIT_STATES);

   typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ERR1, ST_ERR2} state_t;

   // Out of range, wider than the bus, or not aligned to its own size.
   function automatic logic addr_err(input logic [ADDRWIDTH-1:0] addr, input logic [2:0] size);
      logic bad;
      bad = ({1'b0, addr} >= MEM_BYTES) || (size > MAX_SIZE);
      for (int i = 0; i < LANE_BITS; i++)
         if (i < int'(size) && addr[i])
            bad = 1'b1;
      return bad;
   endfunction

   // A lane is enabled when it falls in the same 2^size-byte block as the address.
   function automatic logic [BYTES-1:0] lane_en(input logic [LANE_BITS-1:0] lane, input logic [2:0] size);
      logic [BYTES-1:0] en;
      for (int k = 0; k < BYTES; k++)
         en[k] = ((k >> size) == (int'(lane) >> size));
      return en;
   endfunction

   state_t                 state, state_n;
   logic [3:0]             cnt, cnt_n;
   logic                   ready_now;
   logic                   accept;
   logic                   req_err;
   logic                   vld_p1;
   logic                   write_p1;
   logic [REG_AW-1:0]      addr_p1;
   logic [2:0]             size_p1;
   logic [WORD_AW-1:0]     word_idx;
   logic [LANE_BITS-1:0]   lane;
   logic [BYTES-1:0]       be;
   logic                   wr_en;
   logic [DATAWIDTH-1:0]   mem [MEM_DEPTH];
   logic                   unused;

   assign unused    = ^{HBURST, HPROT, HMASTLOCK, HTRANS[0]};
   assign ready_now = (state == ST_IDLE) || (state == ST_ERR2);
   assign accept    = HSEL & HREADY & HTRANS[1] & ready_now;
   assign req_err   = addr_err(HADDR, HSIZE);

   always_comb begin
      state_n   = state;
      cnt_n     = cnt;
      HREADYOUT = 1'b1;
      HRESP     = 1'b0;
      case (state)
         ST_IDLE, ST_ERR2: begin
            HRESP   = (state == ST_ERR2);
            state_n = ST_IDLE;
            if (accept) begin
               if (req_err) begin
                  state_n = ST_ERR1;
               end else if (WAIT_LOAD != 4'd0) begin
                  state_n = ST_WAIT;
                  cnt_n   = WAIT_LOAD;
               end
            end
         end
         ST_WAIT: begin
            HREADYOUT = 1'b0;
            cnt_n     = cnt - 4'd1;
            if (cnt <= 4'd1)
               state_n = ST_IDLE;
         end
         ST_ERR1: begin
            HREADYOUT = 1'b0;
            HRESP     = 1'b1;
            state_n   = ST_ERR2;
         end
         default: state_n = ST_IDLE;
      endcase
   end

   // Address phase -> data phase (p1) registers
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state    <= ST_IDLE;
         cnt      <= 4'd0;
         vld_p1   <= 1'b0;
         write_p1 <= 1'b0;
         addr_p1  <= '0;
         size_p1  <= 3'd0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         if (ready_now) begin
            vld_p1 <= accept & ~req_err;
            if (accept) begin
               addr_p1  <= HADDR[REG_AW-1:0];
               write_p1 <= HWRITE;
               size_p1  <= HSIZE;
            end
         end
      end
   end

   // Data phase: writes commit on the completing edge, reads are muxed from the array
   assign word_idx = addr_p1[REG_AW-1:LANE_BITS];
   assign lane     = addr_p1[LANE_BITS-1:0];
   assign be       = lane_en(lane, size_p1);
   assign wr_en    = ready_now & vld_p1 & write_p1;

   always_ff @(posedge HCLK) begin
      for (int k = 0; k < BYTES; k++)
         if (wr_en && be[k])
            mem[word_idx][8*k +: 8] <= HWDATA[8*k +: 8];
   end

   assign HRDATA = (ready_now & vld_p1 & ~write_p1) ? mem[word_idx] : '0;

endmodule

// File: tb/tb_ahb_lite_mem_slave.sv
// Bench for ahb_lite_mem_slave: a zero-wait and a three-wait instance behind one
// master, driven by a pipelined beat engine and compared against a byte-level memory model.
module tb_ahb_lite_mem_slave;

   localparam int DEPTH = 256;
   localparam int MAXB  = 300;

   logic        HCLK = 1'b0;
   logic        HRESETn;
   logic        hsel, sel, force_lo, hwrite;
   logic [31:0] haddr, hwdata;
   logic [1:0]  htrans;
   logic [2:0]  hsize;
   logic        ro0, ro1, rs0, rs1;
   logic [31:0] rd0, rd1;
   logic        bus_ready, bus_resp, hready_in;
   logic [31:0] bus_rdata;

   assign bus_ready = sel ? ro1 : ro0;
   assign bus_resp  = sel ? rs1 : rs0;
   assign bus_rdata = sel ? rd1 : rd0;
   assign hready_in = bus_ready & ~force_lo;

   always #5 HCLK = ~HCLK;

   ahb_lite_mem_slave #(.DATAWIDTH(32), .ADDRWIDTH(32), .MEM_DEPTH(DEPTH), .WAIT_STATES(0)) u_ws0 (
      .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(hsel & ~sel), .HADDR(haddr), .HTRANS(htrans),
      .HWRITE(hwrite), .HSIZE(hsize), .HBURST(3'b000), .HPROT(4'b0011), .HMASTLOCK(1'b0),
      .HREADY(hready_in), .HWDATA(hwdata), .HRDATA(rd0), .HREADYOUT(ro0), .HRESP(rs0));

   ahb_lite_mem_slave #(.DATAWIDTH(32), .ADDRWIDTH(32), .MEM_DEPTH(DEPTH), .WAIT_STATES(3)) u_ws3 (
      .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(hsel & sel), .HADDR(haddr), .HTRANS(htrans),
      .HWRITE(hwrite), .HSIZE(hsize), .HBURST(3'b001), .HPROT(4'b0011), .HMASTLOCK(1'b0),
      .HREADY(hready_in), .HWDATA(hwdata), .HRDATA(rd1), .HREADYOUT(ro1), .HRESP(rs1));

   int errors = 0;
   int checks = 0;

   logic [31:0] ref_mem [2][DEPTH];

   logic [31:0] b_addr  [MAXB];
   logic [31:0] b_wdata [MAXB];
   logic        b_write [MAXB];
   logic        b_sel   [MAXB];
   logic [2:0]  b_size  [MAXB];
   logic [1:0]  b_trans [MAXB];
   logic [31:0] r_rdata [MAXB];
   logic        r_resp  [MAXB];
   logic        r_errlow[MAXB];
   logic        r_done  [MAXB];
   int          r_waits [MAXB];
   int          nb;

   function automatic bit ref_err(input logic [31:0] a, input logic [2:0] s);
      return (a >= 32'(DEPTH * 4)) || (s > 3'd2) || ((a % (32'd1 << s)) != 32'd0);
   endfunction

   task automatic ref_write(input int d, input logic [31:0] a, input logic [2:0] s, input logic [31:0] wd);
      int base, w;
      base = int'(a % 32'd4);
      w    = int'(a / 32'd4);
      for (int k = base; k < base + (1 << s); k++)
         ref_mem[d][w][8*k +: 8] = wd[8*k +: 8];
   endtask

   task automatic drive_idle();
      hsel   = 1'b0;
      htrans = 2'b00;
      hwrite = 1'b0;
      haddr  = 32'd0;
      hsize  = 3'd0;
   endtask

   task automatic add_beat(input logic [31:0] a, input logic w, input logic [2:0] s,
                           input logic [31:0] d, input logic [1:0] t, input logic hs);
      b_addr[nb]  = a;
      b_write[nb] = w;
      b_size[nb]  = s;
      b_wdata[nb] = d;
      b_trans[nb] = t;
      b_sel[nb]   = hs;
      nb++;
   endtask

   // Pipelined master: address of beat n overlaps the data phase of beat n-1.
   task automatic run_beats();
      int   nxt, dpi, cycles, limit;
      logic rdy;
      nxt = 0; dpi = -1; cycles = 0; limit = nb * 6 + 20;
      for (int i = 0; i < nb; i++) begin
         r_waits[i] = 0; r_errlow[i] = 1'b0; r_done[i] = 1'b0; r_resp[i] = 1'b0; r_rdata[i] = 32'd0;
      end
      while ((nxt < nb || dpi >= 0) && cycles < limit) begin
         @(negedge HCLK);
         cycles++;
         rdy = hready_in;
         if (dpi >= 0) begin
            hwdata = b_wdata[dpi];
            if (!rdy) begin
               r_waits[dpi]++;
               if (bus_resp) r_errlow[dpi] = 1'b1;
               checks++;
               if (bus_rdata !== 32'd0) begin
                  errors++;
                  $display("FAIL stall_rdata beat %0d: HRDATA=%h, expected 0", dpi, bus_rdata);
               end
            end else begin
               r_rdata[dpi] = bus_rdata;
               r_resp[dpi]  = bus_resp;
               r_done[dpi]  = 1'b1;
            end
         end else begin
            hwdata = $urandom;
            checks++;
            if (bus_ready !== 1'b1 || bus_resp !== 1'b0 || bus_rdata !== 32'd0) begin
               errors++;
               $display("FAIL idle_okay: ready=%b resp=%b rdata=%h, expected 1 0 0", bus_ready, bus_resp, bus_rdata);
            end
         end
         if (nxt < nb) begin
            hsel = b_sel[nxt]; htrans = b_trans[nxt]; hwrite = b_write[nxt];
            haddr = b_addr[nxt]; hsize = b_size[nxt];
         end else begin
            drive_idle();
         end
         if (rdy) begin
            dpi = (nxt < nb && b_sel[nxt] && b_trans[nxt][1]) ? nxt : -1;
            if (nxt < nb) nxt++;
         end
      end
      if (nxt < nb || dpi >= 0) begin
         checks++;
         errors++;
         $display("FAIL run_timeout: %0d cycles used, beats issued %0d of %0d", cycles, nxt, nb);
      end
      drive_idle();
   endtask

   task automatic check_beats(input string tag);
      int          d, exp_waits;
      bit          err;
      logic [31:0] exp_rdata;
      d = int'(sel);
      for (int i = 0; i < nb; i++) begin
         if (!(b_sel[i] && b_trans[i][1])) continue;
         err       = ref_err(b_addr[i], b_size[i]);
         exp_waits = err ? 1 : (d == 1 ? 3 : 0);
         exp_rdata = 32'd0;
         if (!err && b_write[i]) ref_write(d, b_addr[i], b_size[i], b_wdata[i]);
         if (!err && !b_write[i]) exp_rdata = ref_mem[d][b_addr[i] / 32'd4];
         checks++;
         if (r_done[i] !== 1'b1 || r_waits[i] != exp_waits || r_resp[i] !== err || r_errlow[i] !== err) begin
            errors++;
            $display("FAIL %s_resp beat %0d addr %h: done=%b waits=%0d resp=%b errlow=%b, expected 1 %0d %b %b",
                     tag, i, b_addr[i], r_done[i], r_waits[i], r_resp[i], r_errlow[i], exp_waits, err, err);
         end
         checks++;
         if (r_rdata[i] !== exp_rdata) begin
            errors++;
            $display("FAIL %s_rdata beat %0d addr %h: got %h, expected %h", tag, i, b_addr[i], r_rdata[i], exp_rdata);
         end
      end
   endtask

   task automatic test_reset();
      HRESETn = 1'b0; sel = 1'b0; force_lo = 1'b0; hwdata = 32'd0;
      drive_idle();
      repeat (3) @(negedge HCLK);
      checks++;
      if (ro0 !== 1'b1 || rs0 !== 1'b0 || rd0 !== 32'd0) begin
         errors++;
         $display("FAIL reset_ws0: ready=%b resp=%b rdata=%h, expected 1 0 0", ro0, rs0, rd0);
      end
      checks++;
      if (ro1 !== 1'b1 || rs1 !== 1'b0 || rd1 !== 32'd0) begin
         errors++;
         $display("FAIL reset_ws3: ready=%b resp=%b rdata=%h, expected 1 0 0", ro1, rs1, rd1);
      end
      HRESETn = 1'b1;
   endtask

   task automatic init_fill();
      for (int d = 0; d < 2; d++) begin
         sel = d[0];
         nb = 0;
         for (int w = 0; w < DEPTH; w++)
            add_beat(32'(w * 4), 1'b1, 3'd2, $urandom, (w % 4 == 0) ? 2'b10 : 2'b11, 1'b1);
         run_beats();
         check_beats("fill");
      end
   endtask

   task automatic test_zero_wait();
      sel = 1'b0; nb = 0;
      add_beat(32'h10, 1'b1, 3'd2, 32'hDEADBEEF, 2'b10, 1'b1);
      add_beat(32'h10, 1'b0, 3'd2, 32'd0, 2'b10, 1'b1);
      run_beats();
      check_beats("zero_wait");
      checks++;
      if (r_rdata[1] !== 32'hDEADBEEF || r_waits[1] != 0) begin
         errors++;
         $display("FAIL zero_wait_const: rdata=%h waits=%0d, expected deadbeef 0", r_rdata[1], r_waits[1]);
      end
   endtask

   task automatic test_lanes();
      sel = 1'b0; nb = 0;
      add_beat(32'h0, 1'b1, 3'd2, 32'h11223344, 2'b10, 1'b1);
      add_beat(32'h2, 1'b1, 3'd0, 32'h00AA0000, 2'b10, 1'b1);
      add_beat(32'h0, 1'b1, 3'd1, 32'h0000BBCC, 2'b10, 1'b1);
      add_beat(32'h0, 1'b0, 3'd2, 32'd0, 2'b10, 1'b1);
      run_beats();
      check_beats("lanes");
      checks++;
      if (r_rdata[3] !== 32'h11AABBCC) begin
         errors++;
         $display("FAIL lanes_const: got %h, expected 11aabbcc", r_rdata[3]);
      end
   endtask

   task automatic test_wait_states();
      int total;
      sel = 1'b1; nb = 0;
      add_beat(32'h20, 1'b0, 3'd2, 32'd0, 2'b10, 1'b1);
      run_beats();
      check_beats("wait_single");
      checks++;
      if (r_waits[0] != 3 || r_resp[0] !== 1'b0) begin
         errors++;
         $display("FAIL wait_single_const: waits=%0d resp=%b, expected 3 0", r_waits[0], r_resp[0]);
      end
      nb = 0;
      for (int i = 0; i < 4; i++)
         add_beat(32'(32'h40 + i * 4), 1'b0, 3'd2, 32'd0, (i == 0) ? 2'b10 : 2'b11, 1'b1);
      run_beats();
      check_beats("wait_burst");
      total = 0;
      for (int i = 0; i < 4; i++) total += r_waits[i] + 1;
      checks++;
      if (total != 16) begin
         errors++;
         $display("FAIL wait_burst_cycles: got %0d data-phase cycles, expected 16", total);
      end
   endtask

   task automatic test_errors();
      for (int d = 0; d < 2; d++) begin
         sel = d[0]; nb = 0;
         add_beat(32'h400, 1'b0, 3'd2, 32'd0, 2'b10, 1'b1);
         add_beat(32'h2, 1'b1, 3'd2, 32'hCAFEF00D, 2'b10, 1'b1);
         add_beat(32'h8, 1'b1, 3'd3, 32'h12345678, 2'b10, 1'b1);
         add_beat(32'h0, 1'b0, 3'd2, 32'd0, 2'b10, 1'b1);
         add_beat(32'h4, 1'b0, 3'd2, 32'd0, 2'b10, 1'b1);
         run_beats();
         check_beats("errors");
         checks++;
         if (r_resp[0] !== 1'b1 || r_errlow[0] !== 1'b1 || r_waits[0] != 1 || r_rdata[0] !== 32'd0) begin
            errors++;
            $display("FAIL error_const: resp=%b errlow=%b waits=%0d rdata=%h, expected 1 1 1 0",
                     r_resp[0], r_errlow[0], r_waits[0], r_rdata[0]);
         end
      end
   endtask

   task automatic test_ignore();
      sel = 1'b0; nb = 0;
      add_beat(32'h30, 1'b1, 3'd2, 32'h0BADBEEF, 2'b01, 1'b1);
      add_beat(32'h34, 1'b1, 3'd2, 32'h0BADCAFE, 2'b10, 1'b0);
      add_beat(32'h30, 1'b0, 3'd2, 32'd0, 2'b10, 1'b1);
      add_beat(32'h34, 1'b0, 3'd2, 32'd0, 2'b10, 1'b1);
      run_beats();
      check_beats("ignore");
      @(negedge HCLK);
      force_lo = 1'b1;
      hsel = 1'b1; htrans = 2'b10; hwrite = 1'b1; haddr = 32'h38; hsize = 3'd2;
      @(negedge HCLK);
      drive_idle();
      hwdata = ~ref_mem[0][14];
      force_lo = 1'b0;
      checks++;
      if (ro0 !== 1'b1 || rs0 !== 1'b0) begin
         errors++;
         $display("FAIL hready_low_okay: ready=%b resp=%b, expected 1 0", ro0, rs0);
      end
      nb = 0;
      add_beat(32'h38, 1'b0, 3'd2, 32'd0, 2'b10, 1'b1);
      run_beats();
      check_beats("hready_low");
   endtask

   task automatic test_reset_mid_wait();
      logic [31:0] aborted;
      sel = 1'b1;
      aborted = ~ref_mem[1][4];
      @(negedge HCLK);
      hsel = 1'b1; htrans = 2'b10; hwrite = 1'b1; haddr = 32'h10; hsize = 3'd2;
      @(negedge HCLK);
      drive_idle();
      hwdata = aborted;
      checks++;
      if (ro1 !== 1'b0) begin
         errors++;
         $display("FAIL mid_wait_stall: ready=%b, expected 0", ro1);
      end
      #2 HRESETn = 1'b0;
      #1;
      checks++;
      if (ro1 !== 1'b1 || rs1 !== 1'b0 || rd1 !== 32'd0) begin
         errors++;
         $display("FAIL reset_async: ready=%b resp=%b rdata=%h, expected 1 0 0", ro1, rs1, rd1);
      end
      @(negedge HCLK);
      HRESETn = 1'b1;
      nb = 0;
      add_beat(32'h10, 1'b0, 3'd2, 32'd0, 2'b10, 1'b1);
      run_beats();
      check_beats("after_reset");
      checks++;
      if (r_rdata[0] === aborted) begin
         errors++;
         $display("FAIL reset_discard: got %h, which is the aborted write data", r_rdata[0]);
      end
   endtask

   task automatic test_random();
      logic [2:0]  s;
      logic [31:0] a;
      logic [1:0]  t;
      for (int d = 0; d < 2; d++) begin
         sel = d[0]; nb = 0;
         for (int i = 0; i < 60; i++) begin
            s = 3'($urandom_range(0, 2));
            if ($urandom_range(0, 9) == 0) s = 3'd3;
            a = 32'($urandom_range(0, 1023)) & ~((32'd1 << s) - 32'd1);
            case ($urandom_range(0, 19))
               0: a = 32'h400 + 32'($urandom_range(0, 255));
               1: a = a | 32'd1;
               default: ;
            endcase
            t = $urandom_range(0, 1) ? 2'b10 : 2'b11;
            if ($urandom_range(0, 9) == 0) t = 2'($urandom_range(0, 1));
            add_beat(a, 1'($urandom_range(0, 1)), s, $urandom, t, ($urandom_range(0, 9) != 0));
         end
         run_beats();
         check_beats("random");
      end
   endtask

   initial begin
      test_reset();
      init_fill();
      test_zero_wait();
      test_lanes();
      test_wait_states();
      test_errors();
      test_ignore();
      test_reset_mid_wait();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/ahb_lite_mem_slave.md
Name: ahb_lite_mem_slave

Overview:
Parametrised AHB-Lite memory slave. It is the next-generation slave model behind the system decoder/mux and drives the per-slave response bundle: HRDATA, HRESP and HREADYOUT. It adds configurable data width, memory depth and wait states, byte/halfword/word sized accesses, and a two-cycle ERROR response for illegal transfers.

Parameters:
DATAWIDTH, 32, data bus width in bits (32 or 64).
ADDRWIDTH, 32, HADDR width in bits.
MEM_DEPTH, 256, number of DATAWIDTH-bit words in the array.
WAIT_STATES, 0, HREADYOUT-low cycles inserted per valid transfer (0..15).

Ports:
HCLK  in  1  system clock; all state changes on the rising edge.
HRESETn  in  1  asynchronous active-low reset.
HSEL  in  1  slave select from the decoder.
HADDR  in  ADDRWIDTH  byte address (address phase).
HTRANS  in  2  IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
HWRITE  in  1  1 = write, 0 = read (address phase).
HSIZE  in  3  transfer size: 000 byte, 001 halfword, 010 word, 011 doubleword.
HBURST  in  3  burst type; accepted and ignored (every beat is decoded independently).
HPROT  in  4  protection; ignored.
HMASTLOCK  in  1  lock; ignored.
HREADY  in  1  bus-level ready from the mux (previous transfer complete).
HWDATA  in  DATAWIDTH  write data (data phase).
HRDATA  out  DATAWIDTH  read data.
HREADYOUT  out  1  slave ready.
HRESP  out  1  0 = OKAY, 1 = ERROR.

Behaviour:
- Reset (HRESETn low, asynchronous): state=IDLE; HREADYOUT=1; HRESP=0; HRDATA=0; registered address-phase controls cleared. The memory array is not reset.
- Reset mid-operation: any pending write is discarded, the wait counter clears, and the ERROR sequence aborts. The first cycle after reset release accepts a new address phase.
- Address phase is accepted when HSEL & HREADY & HTRANS[1] are all 1. On acceptance the slave registers HADDR, HWRITE, HSIZE and the error flag.
- HTRANS IDLE/BUSY, HSEL=0, or HREADY=0: no transfer is accepted. The next data phase is zero-wait OKAY (HREADYOUT=1, HRESP=0).
- Error flag is set if any of the following holds:
  - HADDR >= MEM_DEPTH*(DATAWIDTH/8);
  - HSIZE > log2(DATAWIDTH/8);
  - HADDR is not aligned to 2^HSIZE.
- FSM states: IDLE, WAIT, ERR1, ERR2.
  - IDLE: accepted valid transfer with WAIT_STATES>0 -> WAIT (counter loaded with WAIT_STATES). Accepted valid transfer with WAIT_STATES=0 -> stay IDLE, zero-wait data phase. Accepted erroneous transfer -> ERR1.
  - WAIT: HREADYOUT=0, HRESP=0, counter decrements. When counter reaches 1, the next cycle is the completing data-phase cycle (HREADYOUT=1), which may accept a new address phase and re-enter WAIT/ERR1 directly.
  - ERR1: HREADYOUT=0, HRESP=1, then -> ERR2.
  - ERR2: HREADYOUT=1, HRESP=1. A new address phase may be accepted here; otherwise -> IDLE.
- Erroneous transfers never write the array. Erroneous reads return HRDATA=0. Error detection takes priority over wait-state insertion.
- Write: performed at the rising edge that ends the data phase (HREADYOUT=1, no error). Only byte lanes selected by the registered address LSBs and HSIZE are updated (little-endian: lane k = bits 8k+7:8k).
- Read: HRDATA = full array word at the registered word address, driven during the read data phase. It is valid on the cycle HREADYOUT=1. HRDATA=0 in all other cycles.
- Width rule: word index = registered HADDR >> log2(DATAWIDTH/8). Upper address bits beyond the array range are caught by the range check; they never wrap into the array.
- Write-then-read to the same address back-to-back: the read data phase returns the newly written data. The write commits at the edge ending the write data phase, before the read data phase samples the array.
- The slave never changes response outputs except at the rising edge of HCLK or on reset.

Test Plan:
- Reset: assert HRESETn=0 mid-WAIT -> HREADYOUT=1, HRESP=0, HRDATA=0 immediately; the pending write to 0x10 is not committed (a later read of 0x10 does not return the aborted write data).
- Zero-wait word write/read (WAIT_STATES=0): NONSEQ write 0x0000_0010 data 0xDEADBEEF, then NONSEQ read 0x10 -> read data phase HREADYOUT=1, HRDATA=0xDEADBEEF.
- Byte/halfword lanes: write word 0x0 = 0x11223344; byte write 0x2 data 0x00AA0000; halfword write 0x0 data 0x0000BBCC -> read 0x0 returns 0x11AABBCC.
- Wait states (WAIT_STATES=3): single read -> exactly 3 cycles of HREADYOUT=0 then 1, HRESP=0; 4-beat SEQ burst -> 16 data-phase cycles total.
- Errors: read at 0x400 with MEM_DEPTH=256 -> HRESP=1/HREADYOUT=0 then HRESP=1/HREADYOUT=1, HRDATA=0. Misaligned word write at 0x2 -> same two-cycle ERROR, array unchanged.
- Ignore rules: HTRANS=BUSY, HSEL=0, or HREADY=0 with a NONSEQ request -> no array change, zero-wait OKAY. NONSEQ accepted in the ERR2 cycle -> serviced normally.
